// File: rtl/video_memory_arbiter.sv
// Single-port video RAM sequencer: the VGA fetch has hard priority, then the clear engine,
// then buffered pixel writes. There is one RAM access per cycle, and all RAM-side outputs are registered.
module video_memory_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iVGAReadRequest,
  input  logic [15:0] iVGAReadAddress,
  output logic [2:0]  oVGAColor,
  output logic        oVGAColorValid,
  input  logic        iWriteRequest,
  input  logic [15:0] iWriteAddress,
  input  logic [2:0]  iWriteData,
  output logic        oWriteFull,
  output logic        oWriteOverflow,
  input  logic        iClearStart,
  input  logic [2:0]  iClearColor,
  output logic        oClearBusy,
  output logic        oClearDone,
  output logic [15:0] oRAMAddress,
  output logic        oRAMWriteEnable,
  output logic [2:0]  oRAMWriteData,
  input  logic [2:0]  iRAMReadData
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [15:0]      clr_cnt;
  logic [2:0]       clr_color;

  logic [15:0]      fifo_addr [FIFO_DEPTH];
  logic [2:0]       fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  logic             push;
  logic             pop;
  logic             clr_write;
  logic             clr_last;
  logic             vga_d1;
  logic             vga_d2;

  // Grant decode: VGA > clear > FIFO.
  assign push       = iWriteRequest && !oWriteFull;
  assign clr_write  = (state == CLEAR) && !iVGAReadRequest;
  assign clr_last   = clr_write && (clr_cnt == 16'hFFFF);
  assign pop        = !iVGAReadRequest && (state == IDLE) && (count != '0);
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  // Clear engine FSM.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      clr_color  <= '0;
      oClearBusy <= 1'b0;
      oClearDone <= 1'b0;
    end else begin
      oClearDone <= clr_last;
      case (state)
        IDLE: begin
          if (iClearStart) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            clr_color  <= iClearColor;
            oClearBusy <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_write) begin
            clr_cnt <= clr_cnt + 16'd1;
            if (clr_last) begin
              state      <= IDLE;
              oClearBusy <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          oClearBusy <= 1'b0;
        end
      endcase
    end
  end

  // Write-buffer storage; contents are don't-care while empty.
  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= iWriteAddress;
      fifo_data[wr_ptr] <= iWriteData;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      oWriteFull     <= 1'b0;
      oWriteOverflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count      <= count_next;
      oWriteFull <= (count_next == CNT_W'(FIFO_DEPTH));
      if (iWriteRequest && oWriteFull) oWriteOverflow <= 1'b1;
    end
  end

  // RAM port; the address holds its last value when the RAM is idle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oRAMAddress     <= '0;
      oRAMWriteEnable <= 1'b0;
      oRAMWriteData   <= '0;
    end else if (iVGAReadRequest) begin
      oRAMAddress     <= iVGAReadAddress;
      oRAMWriteEnable <= 1'b0;
    end else if (clr_write) begin
      oRAMAddress     <= clr_cnt;
      oRAMWriteEnable <= 1'b1;
      oRAMWriteData   <= clr_color;
    end else if (pop) begin
      oRAMAddress     <= fifo_addr[rd_ptr];
      oRAMWriteEnable <= 1'b1;
      oRAMWriteData   <= fifo_data[rd_ptr];
    end else begin
      oRAMWriteEnable <= 1'b0;
    end
  end

  // Two-stage fetch tracker: address out, RAM read, then capture.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      vga_d1         <= 1'b0;
      vga_d2         <= 1'b0;
      oVGAColor      <= '0;
      oVGAColorValid <= 1'b0;
    end else begin
      vga_d1         <= iVGAReadRequest;
      vga_d2         <= vga_d1;
      oVGAColorValid <= vga_d2;
      if (vga_d2) oVGAColor <= iRAMReadData;
    end
  end

endmodule

// File: tb/tb_video_memory_arbiter.sv
// Bench for video_memory_arbiter: a behavioural RAM, plus a queue and shadow-frame reference
// model of the grant rules, driven by directed and randomized scenarios.
module tb_video_memory_arbiter;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vga_req, wr_req, clr_start;
  logic [15:0] vga_addr, wr_addr;
  logic [2:0]  wr_data, clr_color;
  logic [2:0]  vga_color;
  logic        vga_valid, wr_full, wr_ovf, clr_busy, clr_done;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [2:0]  ram_wdata, ram_rd;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  video_memory_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .Clock(clk), .Reset(rst_n),
    .iVGAReadRequest(vga_req), .iVGAReadAddress(vga_addr),
    .oVGAColor(vga_color), .oVGAColorValid(vga_valid),
    .iWriteRequest(wr_req), .iWriteAddress(wr_addr), .iWriteData(wr_data),
    .oWriteFull(wr_full), .oWriteOverflow(wr_ovf),
    .iClearStart(clr_start), .iClearColor(clr_color),
    .oClearBusy(clr_busy), .oClearDone(clr_done),
    .oRAMAddress(ram_addr), .oRAMWriteEnable(ram_we), .oRAMWriteData(ram_wdata),
    .iRAMReadData(ram_rd)
  );

  // Synchronous-read RAM, read-before-write.
  logic [2:0] ram [65536];
  always @(posedge clk) begin
    ram_rd <= ram[ram_addr];
    if (ram_we) ram[ram_addr] <= ram_wdata;
  end

  // Reference model: the pending-write queue and a shadow of the frame contents.
  typedef struct packed {logic [15:0] a; logic [2:0] d;} wr_t;
  wr_t         q[$];
  wr_t         m_e;
  logic [2:0]  shadow [65536];
  bit          pw_v;
  logic [15:0] pw_a;
  logic [2:0]  pw_d;
  bit          p0_v, p1_v;
  logic [2:0]  p0_c, p1_c;
  bit          m_clearing, m_was_clr, m_was_full;
  int          m_cnt;
  logic [2:0]  m_col;
  logic [15:0] m_addr;
  bit          m_we, m_rd, m_valid, m_full, m_ovf, m_busy, m_done;
  logic [2:0]  m_wdata, m_color;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      pw_v = 0; p0_v = 0; p1_v = 0; m_clearing = 0; m_cnt = 0;
      m_addr = 0; m_we = 0; m_rd = 0; m_wdata = 0; m_color = 0;
      m_valid = 0; m_full = 0; m_ovf = 0; m_busy = 0; m_done = 0;
    end else begin
      if (pw_v) shadow[pw_a] = pw_d;
      pw_v = 0;
      m_valid = p1_v;
      if (p1_v) m_color = p1_c;
      p1_v = p0_v; p1_c = p0_c; p0_v = 0;
      m_was_clr = m_clearing;
      m_was_full = (q.size() == DEPTH);
      m_rd = 0; m_we = 0; m_done = 0;
      if (vga_req) begin
        m_rd = 1; m_addr = vga_addr; p0_v = 1; p0_c = shadow[vga_addr];
      end else if (m_was_clr) begin
        m_we = 1; m_addr = 16'(m_cnt); m_wdata = m_col;
        if (m_cnt == 65535) begin m_clearing = 0; m_done = 1; m_cnt = 0; end
        else m_cnt = m_cnt + 1;
      end else if (q.size() > 0) begin
        m_e = q.pop_front();
        m_we = 1; m_addr = m_e.a; m_wdata = m_e.d;
      end
      if (m_we) begin pw_v = 1; pw_a = m_addr; pw_d = m_wdata; end
      if (!m_was_clr && clr_start) begin m_clearing = 1; m_cnt = 0; m_col = clr_color; end
      if (wr_req) begin
        if (m_was_full) m_ovf = 1;
        else q.push_back({wr_addr, wr_data});
      end
      m_full = (q.size() == DEPTH);
      m_busy = m_clearing;
    end
  end

  task automatic idle_inputs();
    vga_req = 0; vga_addr = 0; wr_req = 0; wr_addr = 0; wr_data = 0;
    clr_start = 0; clr_color = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    n_cmp++; if (ram_addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", ram_addr); end
    n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", ram_we); end
    n_cmp++; if (ram_wdata !== 3'd0) begin n_fail++; $display("FAIL reset_wdata got %h exp 0", ram_wdata); end
    n_cmp++; if (vga_color !== 3'd0) begin n_fail++; $display("FAIL reset_color got %h exp 0", vga_color); end
    n_cmp++; if (vga_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", vga_valid); end
    n_cmp++; if (wr_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", wr_full); end
    n_cmp++; if (wr_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", wr_ovf); end
    n_cmp++; if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", clr_busy); end
    n_cmp++; if (clr_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", clr_done); end
    @(posedge clk); #1;
    rst_n = 1;
    step();
  endtask

  task automatic test_vga_fetch();
    ram[16'h1234] = 3'b101; shadow[16'h1234] = 3'b101;
    vga_req = 1; vga_addr = 16'h1234;
    step();
    vga_req = 0;
    n_cmp++; if (ram_addr !== 16'h1234 || ram_we !== 1'b0) begin n_fail++; $display("FAIL fetch_addr got %h/%b exp 1234/0", ram_addr, ram_we); end
    n_cmp++; if (vga_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_early_valid got %b exp 0", vga_valid); end
    step();
    n_cmp++; if (vga_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_k1_valid got %b exp 0", vga_valid); end
    step();
    n_cmp++; if (vga_valid !== 1'b1 || vga_color !== 3'b101) begin n_fail++; $display("FAIL fetch_color got %b/%b exp 1/101", vga_valid, vga_color); end
    step();
    n_cmp++; if (vga_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_valid_drop got %b exp 0", vga_valid); end
  endtask

  task automatic test_fifo_order();
    for (int c = 0; c < 5; c++) begin
      vga_req = 1; vga_addr = 16'h0040;
      wr_req = (c < 2); wr_addr = 16'h0010 + 16'(c); wr_data = (c == 0) ? 3'b001 : 3'b010;
      step();
      n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL order_vga_block cyc %0d we got %b exp 0", c, ram_we); end
    end
    idle_inputs();
    step();
    n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 16'h0010 || ram_wdata !== 3'b001) begin n_fail++; $display("FAIL order_first got %b/%h/%b exp 1/0010/001", ram_we, ram_addr, ram_wdata); end
    step();
    n_cmp++; if (ram_we !== 1'b1 || ram_addr !== 16'h0011 || ram_wdata !== 3'b010) begin n_fail++; $display("FAIL order_second got %b/%h/%b exp 1/0011/010", ram_we, ram_addr, ram_wdata); end
    vga_req = 1; vga_addr = 16'h0010;
    step();
    n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL order_drained we got %b exp 0", ram_we); end
    vga_addr = 16'h0011;
    step();
    vga_req = 0;
    step();
    n_cmp++; if (vga_valid !== 1'b1 || vga_color !== 3'b001) begin n_fail++; $display("FAIL order_readback0 got %b/%b exp 1/001", vga_valid, vga_color); end
    step();
    n_cmp++; if (vga_valid !== 1'b1 || vga_color !== 3'b010) begin n_fail++; $display("FAIL order_readback1 got %b/%b exp 1/010", vga_valid, vga_color); end
  endtask

  task automatic test_full_overflow();
    int writes;
    for (int c = 0; c < 5; c++) begin
      vga_req = 1; vga_addr = 16'h0000;
      wr_req = 1; wr_addr = 16'h0200 + 16'(c); wr_data = 3'(c + 1);
      step();
      if (c == 2) begin
        n_cmp++; if (wr_full !== 1'b0) begin n_fail++; $display("FAIL full_early got %b exp 0", wr_full); end
      end
      if (c == 3) begin
        n_cmp++; if (wr_full !== 1'b1) begin n_fail++; $display("FAIL full_after4 got %b exp 1", wr_full); end
        n_cmp++; if (wr_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b exp 0", wr_ovf); end
      end
    end
    n_cmp++; if (wr_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", wr_ovf); end
    idle_inputs();
    writes = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (ram_we === 1'b1) begin
        n_cmp++;
        if (ram_addr !== 16'h0200 + 16'(writes) || ram_wdata !== 3'(writes + 1)) begin
          n_fail++; $display("FAIL full_drain_%0d got %h/%b exp %h/%b", writes, ram_addr, ram_wdata, 16'h0200 + 16'(writes), 3'(writes + 1));
        end
        writes++;
      end
    end
    n_cmp++; if (writes != 4) begin n_fail++; $display("FAIL full_drain_count got %0d exp 4", writes); end
    n_cmp++; if (wr_ovf !== 1'b1 || wr_full !== 1'b0) begin n_fail++; $display("FAIL ovf_sticky got ovf %b full %b exp 1/0", wr_ovf, wr_full); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      vga_req = ($urandom_range(1, 0) == 1); vga_addr = 16'($urandom_range(63, 0));
      wr_req = ($urandom_range(1, 0) == 1); wr_addr = 16'($urandom_range(63, 0));
      wr_data = 3'($urandom_range(7, 0));
      step();
      n_cmp++; if (ram_we !== m_we) begin n_fail++; $display("FAIL rand_we c%0d got %b exp %b", c, ram_we, m_we); end
      if (m_we || m_rd) begin n_cmp++; if (ram_addr !== m_addr) begin n_fail++; $display("FAIL rand_addr c%0d got %h exp %h", c, ram_addr, m_addr); end end
      if (m_we) begin n_cmp++; if (ram_wdata !== m_wdata) begin n_fail++; $display("FAIL rand_wdata c%0d got %b exp %b", c, ram_wdata, m_wdata); end end
      n_cmp++; if (vga_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid c%0d got %b exp %b", c, vga_valid, m_valid); end
      if (m_valid) begin n_cmp++; if (vga_color !== m_color) begin n_fail++; $display("FAIL rand_color c%0d got %b exp %b", c, vga_color, m_color); end end
      n_cmp++; if (wr_full !== m_full || wr_ovf !== m_ovf) begin n_fail++; $display("FAIL rand_flags c%0d got full %b ovf %b exp %b %b", c, wr_full, wr_ovf, m_full, m_ovf); end
    end
    idle_inputs();
    for (int c = 0; c < 8; c++) step();
  endtask

  task automatic test_clear();
    int  idx, dones, c;
    bit  seen_done, fifo_landed;
    logic [15:0] rd_a [4];
    logic [2:0]  rd_e [4];
    clr_start = 1; clr_color = 3'b111;
    step();
    idle_inputs();
    n_cmp++; if (clr_busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy_start got %b exp 1", clr_busy); end
    idx = 0; dones = 0; seen_done = 0; fifo_landed = 0; c = 0;
    while (!fifo_landed && c < 80000) begin
      vga_req = (c % 64 == 63); vga_addr = 16'($urandom);
      wr_req = (c == 100); wr_addr = 16'h0100; wr_data = 3'b010;
      clr_start = (c == 200); clr_color = 3'b000;
      step();
      c++;
      if (ram_we === 1'b1 && !seen_done) begin
        if (ram_addr !== 16'(idx) || ram_wdata !== 3'b111) begin
          n_cmp++; n_fail++; $display("FAIL clear_write_%0d got %h/%b exp %h/111", idx, ram_addr, ram_wdata, 16'(idx));
        end
        idx++;
      end else if (ram_we === 1'b1 && seen_done) begin
        fifo_landed = 1;
        n_cmp++; if (ram_addr !== 16'h0100 || ram_wdata !== 3'b010) begin n_fail++; $display("FAIL clear_fifo_after got %h/%b exp 0100/010", ram_addr, ram_wdata); end
      end
      if (clr_done === 1'b1) begin dones++; seen_done = 1; end
      if (!seen_done) begin n_cmp++; if (clr_busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy c%0d got %b exp 1", c, clr_busy); end end
      if (m_valid) begin n_cmp++; if (vga_color !== m_color) begin n_fail++; $display("FAIL clear_color c%0d got %b exp %b", c, vga_color, m_color); end end
    end
    idle_inputs();
    n_cmp++; if (idx != 65536) begin n_fail++; $display("FAIL clear_count got %0d exp 65536", idx); end
    n_cmp++; if (dones != 1) begin n_fail++; $display("FAIL clear_done_pulses got %0d exp 1", dones); end
    n_cmp++; if (!fifo_landed) begin n_fail++; $display("FAIL clear_fifo_timeout got 0 exp 1"); end
    n_cmp++; if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy_end got %b exp 0", clr_busy); end
    step();
    rd_a[0] = 16'h0000; rd_a[1] = 16'hFFFF; rd_a[2] = 16'h0100; rd_a[3] = 16'h8000;
    rd_e[0] = 3'b111;   rd_e[1] = 3'b111;   rd_e[2] = 3'b010;   rd_e[3] = 3'b111;
    for (int i = 0; i < 6; i++) begin
      vga_req = (i < 4); vga_addr = rd_a[i % 4];
      step();
      if (i >= 2) begin
        n_cmp++; if (vga_valid !== 1'b1 || vga_color !== rd_e[i-2]) begin n_fail++; $display("FAIL clear_readback_%h got %b/%b exp 1/%b", rd_a[i-2], vga_valid, vga_color, rd_e[i-2]); end
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_clear();
    bit reached;
    int c;
    clr_start = 1; clr_color = 3'b011;
    step();
    idle_inputs();
    reached = 0; c = 0;
    while (!reached && c < 20000) begin
      wr_req = (c == 5 || c == 6); wr_addr = 16'h0300 + 16'(c); wr_data = 3'b100;
      step();
      c++;
      if (ram_we === 1'b1 && ram_addr === 16'h3FFF) reached = 1;
    end
    idle_inputs();
    n_cmp++; if (!reached) begin n_fail++; $display("FAIL midclr_reach got 0 exp 1"); end
    #3 rst_n = 0;
    #1;
    n_cmp++; if (ram_addr !== 16'h0 || ram_we !== 1'b0 || ram_wdata !== 3'd0) begin n_fail++; $display("FAIL midclr_ram got %h/%b/%b exp 0/0/0", ram_addr, ram_we, ram_wdata); end
    n_cmp++; if (vga_color !== 3'd0 || vga_valid !== 1'b0) begin n_fail++; $display("FAIL midclr_vga got %b/%b exp 0/0", vga_color, vga_valid); end
    n_cmp++; if (wr_full !== 1'b0 || wr_ovf !== 1'b0) begin n_fail++; $display("FAIL midclr_flags got %b/%b exp 0/0", wr_full, wr_ovf); end
    n_cmp++; if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin n_fail++; $display("FAIL midclr_clear got %b/%b exp 0/0", clr_busy, clr_done); end
    step();
    rst_n = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      n_cmp++; if (ram_we !== 1'b0 || clr_busy !== 1'b0 || clr_done !== 1'b0) begin n_fail++; $display("FAIL midclr_after c%0d got we %b busy %b done %b exp 0 0 0", i, ram_we, clr_busy, clr_done); end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin ram[i] = 3'd0; shadow[i] = 3'd0; end
    test_reset();
    test_vga_fetch();
    test_fifo_order();
    test_full_overflow();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
